// File: rtl/tdc_multichannel.sv
// Multi-channel time-to-digital converter core.
// Each channel synchronises one raw input, detects the selected edge and
// measures the clk_100m cycle count between consecutive edges. Finished
// measurements wait in a one-deep per-channel slot, are merged by a
// round-robin arbiter and queued in a first-word-fall-through record FIFO.
module tdc_multichannel #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 3,
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk_100m,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] sig_in,
    input  logic [CHANNELS-1:0] ch_enable,
    input  logic [CHANNELS-1:0] edge_sel,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [CH_W-1:0]     rec_chan,
    output logic [CNT_W-1:0]    rec_interval,
    output logic                rec_sat,
    output logic [15:0]         drop_count,
    output logic [LVL_W-1:0]    fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [CHANNELS-1:0] pend_vec;
    logic [CHANNELS-1:0] drop_vec;
    logic [CHANNELS-1:0] grant_vec;
    logic [CNT_W-1:0]    hold_int [CHANNELS];
    logic [CHANNELS-1:0] hold_sat;

    logic                grant_any;
    logic [CH_W-1:0]     grant_idx;
    logic [CH_W-1:0]     ptr_q, ptr_d;

    logic                fifo_full;
    logic [LVL_W-1:0]    count_q, count_d;
    logic [AW-1:0]       wr_q, rd_q;
    logic [CH_W-1:0]     mem_chan_q [FIFO_DEPTH];
    logic [CNT_W-1:0]    mem_int_q  [FIFO_DEPTH];
    logic                mem_sat_q  [FIFO_DEPTH];
    logic                push, pop;

    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic [4:0]          n_drop;
    logic [16:0]         drop_sum;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   s_prev_q;
            logic                   armed_q;
            logic                   pend_q;
            logic [CNT_W-1:0]       cnt_q;
            logic [CNT_W-1:0]       hold_int_q;
            logic                   hold_sat_q;
            logic                   s_lvl;
            logic                   evt;
            logic                   capture;

            assign s_lvl = sync_q[SYNC_STAGES-1];
            // New level differs from the old one and matches the selected polarity.
            assign evt     = (s_lvl ^ s_prev_q) & (s_lvl ^ edge_sel[gi]) & ch_enable[gi];
            // The slot is free if empty or being emptied by this cycle's grant.
            assign capture = evt & armed_q & (~pend_q | grant_vec[gi]);

            assign pend_vec[gi] = pend_q & ch_enable[gi];
            assign drop_vec[gi] = evt & armed_q & pend_q & ~grant_vec[gi];
            assign hold_int[gi] = hold_int_q;
            assign hold_sat[gi] = hold_sat_q;

            // Free-running synchroniser chain plus the registered copy of s.
            always_ff @(posedge clk_100m or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q   <= '0;
                    s_prev_q <= 1'b0;
                end else begin
                    sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in[gi]};
                    s_prev_q <= s_lvl;
                end
            end

            // Interval counter, arming and the one-deep pending record slot.
            always_ff @(posedge clk_100m or negedge rst_n) begin
                if (!rst_n) begin
                    armed_q    <= 1'b0;
                    pend_q     <= 1'b0;
                    cnt_q      <= '0;
                    hold_int_q <= '0;
                    hold_sat_q <= 1'b0;
                end else if (!ch_enable[gi]) begin
                    armed_q <= 1'b0;
                    pend_q  <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    if (evt) begin
                        cnt_q   <= CNT_W'(1);
                        armed_q <= 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (capture) begin
                        pend_q     <= 1'b1;
                        hold_int_q <= cnt_q;
                        hold_sat_q <= (cnt_q == '1);
                    end else if (grant_vec[gi]) begin
                        pend_q <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Round-robin search from the priority pointer; no grant while the FIFO is full.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (!fifo_full) begin
            for (int off = 0; off < CHANNELS; off++) begin
                idx = int'(ptr_q) + off;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!grant_any && pend_vec[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = CH_W'(idx);
                end
            end
        end
        grant_vec = grant_any ? (CHANNELS'(1) << grant_idx) : '0;
        ptr_d     = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

    // FIFO control and saturating drop counter next-state.
    always_comb begin
        fifo_full = (count_q == LVL_W'(FIFO_DEPTH));
        push      = grant_any;
        pop       = rec_valid & rec_ready;
        count_d   = count_q + LVL_W'(push) - LVL_W'(pop);
        n_drop    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            n_drop = n_drop + 5'(drop_vec[i]);
        end
        drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Pointer, occupancy and drop counter registers.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            count_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            drop_cnt_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
        end
    end

    // Record storage; contents are only visible through the valid-gated head.
    always_ff @(posedge clk_100m) begin
        if (push) begin
            mem_chan_q[wr_q] <= grant_idx;
            mem_int_q[wr_q]  <= hold_int[grant_idx];
            mem_sat_q[wr_q]  <= hold_sat[grant_idx];
        end
    end

    assign rec_valid    = (count_q != '0);
    assign rec_chan     = rec_valid ? mem_chan_q[rd_q] : '0;
    assign rec_interval = rec_valid ? mem_int_q[rd_q]  : '0;
    assign rec_sat      = rec_valid ? mem_sat_q[rd_q]  : 1'b0;
    assign drop_count   = drop_cnt_q;
    assign fifo_level   = count_q;

endmodule

// File: tb/tb_tdc_multichannel.sv
// Testbench for tdc_multichannel: table-driven interval vectors plus
// hand-written sequences, with a record scoreboard checked at the stream output.
module tb_tdc_multichannel;

    logic        clk_100m = 1'b0;
    logic        rst_n;
    logic [3:0]  sig_in, ch_enable, edge_sel;
    logic        rec_ready, rec_valid, rec_sat;
    logic [1:0]  rec_chan;
    logic [31:0] rec_interval;
    logic [15:0] drop_count;
    logic [4:0]  fifo_level;

    logic [3:0]  sig8, en8, sel8;
    logic        ready8, valid8, sat8;
    logic [1:0]  chan8;
    logic [7:0]  int8;
    logic [15:0] drop8;
    logic [4:0]  level8;

    always #5 clk_100m = ~clk_100m;

    tdc_multichannel dut (
        .clk_100m(clk_100m), .rst_n(rst_n), .sig_in(sig_in), .ch_enable(ch_enable),
        .edge_sel(edge_sel), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_chan(rec_chan), .rec_interval(rec_interval), .rec_sat(rec_sat),
        .drop_count(drop_count), .fifo_level(fifo_level)
    );

    tdc_multichannel #(.CNT_W(8)) dut8 (
        .clk_100m(clk_100m), .rst_n(rst_n), .sig_in(sig8), .ch_enable(en8),
        .edge_sel(sel8), .rec_valid(valid8), .rec_ready(ready8),
        .rec_chan(chan8), .rec_interval(int8), .rec_sat(sat8),
        .drop_count(drop8), .fifo_level(level8)
    );

    typedef struct {
        int chan;
        int interval;
        bit sat;
    } rec_t;

    typedef struct {
        int ch;
        int gap;
        bit exp_rec;
        int exp_interval;
        bit exp_sat;
    } vec_t;

    rec_t exp_q[$];
    rec_t exp8_q[$];
    rec_t mon_e, mon8_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard for the main instance.
    always @(negedge clk_100m) begin
        if (rst_n && rec_valid && rec_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_record actual chan=%0d interval=%0d sat=%0d required=none",
                         rec_chan, rec_interval, rec_sat);
            end else begin
                mon_e = exp_q.pop_front();
                if (int'(rec_chan) != mon_e.chan || rec_interval != 32'(mon_e.interval) || rec_sat != mon_e.sat) begin
                    failures++;
                    $display("FAIL record actual chan=%0d interval=%0d sat=%0d required chan=%0d interval=%0d sat=%0d",
                             rec_chan, rec_interval, rec_sat, mon_e.chan, mon_e.interval, mon_e.sat);
                end else begin
                    $display("rec main chan=%0d interval=%0d sat=%0d", rec_chan, rec_interval, rec_sat);
                end
            end
        end
    end

    // Scoreboard for the 8-bit counter instance.
    always @(negedge clk_100m) begin
        if (rst_n && valid8 && ready8) begin
            checks++;
            if (exp8_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_record8 actual chan=%0d interval=%0d sat=%0d required=none",
                         chan8, int8, sat8);
            end else begin
                mon8_e = exp8_q.pop_front();
                if (int'(chan8) != mon8_e.chan || int8 != 8'(mon8_e.interval) || sat8 != mon8_e.sat) begin
                    failures++;
                    $display("FAIL record8 actual chan=%0d interval=%0d sat=%0d required chan=%0d interval=%0d sat=%0d",
                             chan8, int8, sat8, mon8_e.chan, mon8_e.interval, mon8_e.sat);
                end else begin
                    $display("rec cnt8 chan=%0d interval=%0d sat=%0d", chan8, int8, sat8);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input logic [3:0] m);
        sig_in = sig_in | m;
        step();
        sig_in = sig_in & ~m;
    endtask

    task automatic pulse8(input logic [3:0] m);
        sig8 = sig8 | m;
        step();
        sig8 = sig8 & ~m;
    endtask

    task automatic push_exp(input int ch, input int iv, input bit st);
        rec_t r;
        r.chan = ch; r.interval = iv; r.sat = st;
        exp_q.push_back(r);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() + exp8_q.size()) != 0 && n < 2000) begin
            step();
            n++;
        end
        check({name, "_outstanding"}, exp_q.size() + exp8_q.size(), 0);
        steps(3);
        check({name, "_level"}, fifo_level, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rec_valid"}, rec_valid, 0);
        check({tag, "_rec_chan"}, rec_chan, 0);
        check({tag, "_rec_interval"}, rec_interval, 0);
        check({tag, "_rec_sat"}, rec_sat, 0);
        check({tag, "_drop_count"}, drop_count, 0);
        check({tag, "_fifo_level"}, fifo_level, 0);
    endtask

    initial begin
        vec_t vecs[12];
        rec_t r;
        vecs[0]  = '{0, 5,    0, 0,    0};
        vecs[1]  = '{0, 1000, 1, 1000, 0};
        vecs[2]  = '{0, 1000, 1, 1000, 0};
        vecs[3]  = '{0, 1000, 1, 1000, 0};
        vecs[4]  = '{0, 1000, 1, 1000, 0};
        vecs[5]  = '{1, 20,   0, 0,    0};
        vecs[6]  = '{1, 37,   1, 37,   0};
        vecs[7]  = '{1, 2,    1, 2,    0};
        vecs[8]  = '{3, 10,   0, 0,    0};
        vecs[9]  = '{3, 2,    1, 2,    0};
        vecs[10] = '{3, 2,    1, 2,    0};
        vecs[11] = '{3, 513,  1, 513,  0};

        rst_n = 1'b0; sig_in = '0; ch_enable = '0; edge_sel = '0; rec_ready = 1'b1;
        sig8 = '0; en8 = '0; sel8 = '0; ready8 = 1'b1;
        steps(3);
        check_reset("reset");
        rst_n = 1'b1;
        steps(2);

        // Saturation on the 8-bit instance: 300-cycle gap then a 100-cycle gap.
        en8 = 4'b0010;
        steps(5);
        pulse8(4'b0010);
        steps(299);
        r.chan = 1; r.interval = 255; r.sat = 1'b1; exp8_q.push_back(r);
        pulse8(4'b0010);
        steps(99);
        r.chan = 1; r.interval = 100; r.sat = 1'b0; exp8_q.push_back(r);
        pulse8(4'b0010);
        wait_drain("sat8");

        // Table-driven single-channel intervals, rising edges.
        ch_enable = 4'hF;
        steps(5);
        for (int i = 0; i < 12; i++) begin
            steps(vecs[i].gap - 1);
            if (vecs[i].exp_rec) push_exp(vecs[i].ch, vecs[i].exp_interval, vecs[i].exp_sat);
            pulse(4'(1 << vecs[i].ch));
        end
        wait_drain("table");
        check("table_drop_count", drop_count, 0);

        // Simultaneous edges on all channels, then pointer at 2 with {0,3} pending.
        ch_enable = '0;
        step();
        ch_enable = 4'hF;
        steps(5);
        pulse(4'hF);
        for (int k = 0; k < 2; k++) begin
            steps(49);
            for (int c = 0; c < 4; c++) push_exp(c, 50, 1'b0);
            pulse(4'hF);
        end
        steps(29);
        push_exp(1, 30, 1'b0);
        pulse(4'b0010);
        steps(9);
        push_exp(3, 40, 1'b0);
        push_exp(0, 40, 1'b0);
        pulse(4'b1001);
        wait_drain("rr");

        // Back-pressure: FIFO fills, one record pends, the rest are dropped.
        ch_enable = '0;
        step();
        ch_enable = 4'b0001;
        rec_ready = 1'b0;
        steps(5);
        for (int k = 0; k < 30; k++) begin
            if (k >= 1 && k <= 17) push_exp(0, 10, 1'b0);
            pulse(4'b0001);
            steps(9);
        end
        steps(10);
        check("full_fifo_level", fifo_level, 16);
        check("full_rec_valid", rec_valid, 1);
        check("full_drop_count", drop_count, 12);
        rec_ready = 1'b1;
        wait_drain("full");
        check("full_drop_count_after", drop_count, 12);

        // Falling-edge mode on ch2, then rising after a disable/enable cycle.
        ch_enable = '0;
        edge_sel  = 4'b0100;
        step();
        ch_enable = 4'b0100;
        steps(5);
        for (int w = 0; w < 3; w++) begin
            sig_in[2] = 1'b1;
            steps(40);
            if (w >= 1) push_exp(2, 100, 1'b0);
            sig_in[2] = 1'b0;
            steps(60);
        end
        ch_enable = '0;
        edge_sel  = '0;
        step();
        ch_enable = 4'b0100;
        steps(5);
        for (int w = 0; w < 3; w++) begin
            if (w >= 1) push_exp(2, 100, 1'b0);
            sig_in[2] = 1'b1;
            steps(40);
            sig_in[2] = 1'b0;
            steps(60);
        end
        wait_drain("edge");

        // Reset mid-operation with five records queued and ch0 armed.
        ch_enable = 4'b0001;
        rec_ready = 1'b0;
        steps(5);
        for (int k = 0; k < 6; k++) begin
            pulse(4'b0001);
            steps(19);
        end
        steps(5);
        check("pre_reset_level", fifo_level, 5);
        rst_n = 1'b0;
        exp_q.delete();
        step();
        check_reset("mid_reset");
        rst_n = 1'b1;
        steps(2);
        check("post_reset_drop_count", drop_count, 0);
        rec_ready = 1'b1;
        pulse(4'b0001);
        steps(29);
        check("post_reset_arm_only_valid", rec_valid, 0);
        check("post_reset_arm_only_level", fifo_level, 0);
        push_exp(0, 30, 1'b0);
        pulse(4'b0001);
        wait_drain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
